// File: rtl/win_tile_buf.sv
// win_tile_buf: 4-row circular band buffer feeding overlapping 4x4 stride-2 tiles.
// Define WIN_TILE_PAD_EN for a virtual 1-pixel zero border ("same" 3x3 tiling).
module win_tile_buf #(
  parameter int IMG_W     = 8,
  parameter int IMG_H     = 8,
  parameter int PIX_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PIX_WIDTH-1:0]    pix_in,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  output logic [16*PIX_WIDTH-1:0] tile,
  output logic                    tile_valid,
  input  logic                    tile_ready,
  output logic [7:0]              tile_row,
  output logic [7:0]              tile_col,
  output logic                    frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

`ifdef WIN_TILE_PAD_EN
  localparam int         PAD       = 1;
  localparam logic [7:0] LAST_TROW = 8'(IMG_H/2-1);
  localparam logic [7:0] LAST_TCOL = 8'(IMG_W/2-1);
`else
  localparam int         PAD       = 0;
  localparam logic [7:0] LAST_TROW = 8'(IMG_H/2-2);
  localparam logic [7:0] LAST_TCOL = 8'(IMG_W/2-2);
`endif

  typedef enum logic {LOAD, EMIT} state_t;

  state_t state;
  state_t state_nx;

  logic [PIX_WIDTH-1:0] mem [4][IMG_W];

  logic                    live;
  logic [1:0]              base;
  logic [1:0]              fill;
  logic [1:0]              fill_end;
  logic [1:0]              slot_off;
  logic [1:0]              wr_row;
  logic [CW-1:0]           col;
  logic                    first_band;
  logic                    last_band;
  logic                    accept;
  logic                    band_full;
  logic                    take;
  logic                    last_tile;
  logic [16*PIX_WIDTH-1:0] tile_nx;

  // Rows a band must load and the band slot the first one lands in.
  always_comb begin
    first_band = (tile_row == 8'd0);
    last_band  = (tile_row == LAST_TROW);
`ifdef WIN_TILE_PAD_EN
    slot_off = first_band ? 2'd1 : 2'd2;
    fill_end = first_band ? 2'd2 : (last_band ? 2'd0 : 2'd1);
`else
    slot_off = first_band ? 2'd0 : 2'd2;
    fill_end = first_band ? 2'd3 : 2'd1;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LOAD;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      LOAD:    if (band_full) state_nx = EMIT;
      EMIT:    if (last_tile) state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  always_comb begin
    pix_ready  = live && (state == LOAD);
    accept     = pix_ready && pix_valid;
    wr_row     = base + slot_off + fill;
    band_full  = accept && (col == CW'(IMG_W-1)) && (fill == fill_end);
    tile_valid = (state == EMIT);
    take       = tile_valid && tile_ready;
    last_tile  = take && (tile_col == LAST_TCOL);
    frame_done = last_tile && last_band;
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_row][col] <= pix_in;
  end

  // Next tile; the pixel being written this edge is forwarded so the
  // first tile can be registered on the band's last accept.
  always_comb begin
    logic [7:0]           k;
    logic [1:0]           pr;
    int                   cc;
    logic [PIX_WIDTH-1:0] px;
    tile_nx = '0;
    k  = (state == EMIT) ? tile_col + 8'd1 : 8'd0;
    pr = '0;
    cc = 0;
    px = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        pr = base + 2'(r);
        cc = 2*int'(k) + c - PAD;
        px = '0;
        if (cc >= 0 && cc < IMG_W) begin
          if (accept && pr == wr_row && CW'(cc) == col)
            px = pix_in;
          else
            px = mem[pr][CW'(cc)];
        end
`ifdef WIN_TILE_PAD_EN
        if ((r == 0 && first_band) || (r == 3 && last_band))
          px = '0;
`endif
        tile_nx[(15-(4*r+c))*PIX_WIDTH +: PIX_WIDTH] = px;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live     <= 1'b0;
      base     <= '0;
      fill     <= '0;
      col      <= '0;
      tile     <= '0;
      tile_row <= '0;
      tile_col <= '0;
    end else begin
      live <= 1'b1;
      if (accept) begin
        if (col == CW'(IMG_W-1)) begin
          col  <= '0;
          fill <= band_full ? 2'd0 : fill + 2'd1;
        end else begin
          col <= col + CW'(1);
        end
      end
      if (band_full) tile <= tile_nx;
      if (take) begin
        if (last_tile) begin
          tile_col <= '0;
          if (last_band) begin
            tile_row <= '0;
            base     <= '0;
          end else begin
            tile_row <= tile_row + 8'd1;
            base     <= base + 2'd2;
          end
        end else begin
          tile_col <= tile_col + 8'd1;
          tile     <= tile_nx;
        end
      end
    end
  end

endmodule
